// File: rtl/skew_pingpong_buf.sv
// Double-buffered LANES x DEPTH operand tile buffer with row/column writes and a
// diagonal-skewed drain. Optional sticky error output: define SKEW_BUF_ERR_EN.
module skew_pingpong_buf #(
  parameter int unsigned BITS  = 8,
  parameter int unsigned LANES = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned VEC  = (LANES > DEPTH) ? LANES : DEPTH,
  localparam int unsigned IW   = (VEC > 1) ? $clog2(VEC) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr_en,
  input  logic                   i_wr_tr,
  input  logic [IW-1:0]          i_wr_idx,
  input  logic [VEC*BITS-1:0]    i_wr_data,
  input  logic                   i_wr_commit,
  output logic                   o_wr_ready,
  input  logic                   i_rd_start,
  input  logic                   i_rd_stall,
  output logic                   o_rd_ready,
  output logic [LANES*BITS-1:0]  o_out_data,
  output logic                   o_out_valid,
  output logic                   o_out_last
`ifdef SKEW_BUF_ERR_EN
  ,
  output logic                   o_err_flag
`endif
);

  localparam int unsigned NSL = DEPTH + LANES - 1;
  localparam int unsigned TW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [TW-1:0] TLAST = TW'(NSL - 1);

  typedef enum logic [1:0] {BkEmpty, BkFull, BkDrain} bank_e;
  typedef enum logic {StIdle, StDrain} state_e;

  logic [BITS-1:0]       r_mem [2][LANES][DEPTH];
  bank_e                 r_bst [2];
  bank_e                 w_bst_nxt [2];
  logic                  r_wr_ptr, w_wr_ptr_nxt;
  logic                  r_rd_ptr, w_rd_ptr_nxt;
  state_e                r_state, w_state_nxt;
  logic [TW-1:0]         r_t, w_t_nxt;
  logic                  w_emit, w_zero, w_bank;
  logic                  w_wr_ready, w_wr_acc;
  logic [LANES*BITS-1:0] w_slice, r_out_data;
  logic                  r_out_valid, r_out_last;

  assign w_wr_ready  = (r_bst[r_wr_ptr] == BkEmpty);
  assign w_wr_acc    = i_wr_en && w_wr_ready;
  assign o_wr_ready  = w_wr_ready;
  assign o_rd_ready  = (r_bst[r_rd_ptr] == BkFull);
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;

  // Row write fills M[idx][*], column write fills M[*][idx]; out-of-range idx matches nothing.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < LANES; i++) begin
          for (int k = 0; k < DEPTH; k++) begin
            r_mem[b][i][k] <= '0;
          end
        end
      end
    end else if (w_wr_acc) begin
      for (int i = 0; i < LANES; i++) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (!i_wr_tr && int'(i_wr_idx) == i) begin
            r_mem[r_wr_ptr][i][k] <= i_wr_data[k*BITS +: BITS];
          end else if (i_wr_tr && int'(i_wr_idx) == k) begin
            r_mem[r_wr_ptr][i][k] <= i_wr_data[i*BITS +: BITS];
          end
        end
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_t_nxt      = r_t;
    w_rd_ptr_nxt = r_rd_ptr;
    w_wr_ptr_nxt = r_wr_ptr;
    w_bst_nxt    = r_bst;
    w_emit       = 1'b0;
    w_zero       = 1'b0;
    w_bank       = r_rd_ptr;

    if (i_wr_commit && w_wr_ready) begin
      w_bst_nxt[r_wr_ptr] = BkFull;
      w_wr_ptr_nxt        = ~r_wr_ptr;
    end

    unique case (r_state)
      StIdle: begin
        if (i_rd_start && r_bst[r_rd_ptr] == BkFull) begin
          w_state_nxt         = StDrain;
          w_t_nxt             = '0;
          w_bst_nxt[r_rd_ptr] = BkDrain;
          w_emit              = 1'b1;
        end
      end
      StDrain: begin
        if (!i_rd_stall) begin
          if (r_t == TLAST) begin
            w_bst_nxt[r_rd_ptr] = BkEmpty;
            w_rd_ptr_nxt        = ~r_rd_ptr;
            // Back-to-back tile: the other bank must already be FULL this cycle.
            if (i_rd_start && r_bst[~r_rd_ptr] == BkFull) begin
              w_t_nxt              = '0;
              w_bst_nxt[~r_rd_ptr] = BkDrain;
              w_bank               = ~r_rd_ptr;
              w_emit               = 1'b1;
            end else begin
              w_state_nxt = StIdle;
              w_zero      = 1'b1;
            end
          end else begin
            w_t_nxt = r_t + TW'(1);
            w_emit  = 1'b1;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Lane i carries M[i][t-i]; cells outside the diagonal band pad with zero.
  always_comb begin
    w_slice = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (int'(w_t_nxt) == i + k) begin
          w_slice[i*BITS +: BITS] = r_mem[w_bank][i][k];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_t         <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_bst[0]    <= BkEmpty;
      r_bst[1]    <= BkEmpty;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_t      <= w_t_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_bst    <= w_bst_nxt;
      if (w_emit) begin
        r_out_data  <= w_slice;
        r_out_valid <= 1'b1;
        r_out_last  <= (w_t_nxt == TLAST);
      end else if (w_zero) begin
        r_out_data  <= '0;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

`ifdef SKEW_BUF_ERR_EN
  logic r_err;
  logic w_err_evt;
  logic w_idx_bad;

  assign w_idx_bad = i_wr_tr ? (int'(i_wr_idx) >= int'(DEPTH)) : (int'(i_wr_idx) >= int'(LANES));
  assign w_err_evt = ((i_wr_en || i_wr_commit) && !w_wr_ready) || (i_wr_en && w_idx_bad);
  assign o_err_flag = r_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (w_err_evt) begin
      r_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_skew_pingpong_buf.sv
// Bench for skew_pingpong_buf: a 4x4 instance and an 8-lane x 3-deep instance,
// checked against tile matrices and a diagonal-slice formula.
module tb_skew_pingpong_buf;

  logic clk;
  logic rst;
  logic wr_tr, stall;
  logic [2:0] idx;
  logic [63:0] data;

  logic en1, cm1, rs1, wrdy1, rrdy1, v1, l1;
  logic [31:0] d1;
  logic en2, cm2, rs2, wrdy2, rrdy2, v2, l2;
  logic [63:0] d2;
`ifdef SKEW_BUF_ERR_EN
  logic err1, err2;
`endif

  skew_pingpong_buf #(.BITS(8), .LANES(4), .DEPTH(4)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_wr_en(en1), .i_wr_tr(wr_tr), .i_wr_idx(idx[1:0]),
    .i_wr_data(data[31:0]), .i_wr_commit(cm1), .o_wr_ready(wrdy1), .i_rd_start(rs1),
    .i_rd_stall(stall), .o_rd_ready(rrdy1), .o_out_data(d1), .o_out_valid(v1),
    .o_out_last(l1)
`ifdef SKEW_BUF_ERR_EN
    , .o_err_flag(err1)
`endif
  );

  skew_pingpong_buf #(.BITS(8), .LANES(8), .DEPTH(3)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_wr_en(en2), .i_wr_tr(wr_tr), .i_wr_idx(idx),
    .i_wr_data(data), .i_wr_commit(cm2), .o_wr_ready(wrdy2), .i_rd_start(rs2),
    .i_rd_stall(stall), .o_rd_ready(rrdy2), .o_out_data(d2), .o_out_valid(v2),
    .o_out_last(l2)
`ifdef SKEW_BUF_ERR_EN
    , .o_err_flag(err2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int mdl [2][8][8];
  int mdl2 [8][8];
  int wb1;
  int cyc = 0;
  logic [63:0] exp_q[$];
  logic        exp_l_q[$];
  logic [63:0] obs_q[$];
  logic        obs_l_q[$];
  int          obs_c_q[$];

  // Record every valid slice with its cycle number, sampled clear of the edge.
  always begin
    @(posedge clk);
    #2;
    cyc++;
    if (!rst && v1) begin
      obs_q.push_back({32'b0, d1}); obs_l_q.push_back(l1); obs_c_q.push_back(cyc);
    end
    if (!rst && v2) begin
      obs_q.push_back(d2); obs_l_q.push_back(l2); obs_c_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] slice_of(input int which, input int b, input int t);
    logic [63:0] s;
    int nl, nd, k, val;
    s  = '0;
    nl = (which == 1) ? 4 : 8;
    nd = (which == 1) ? 4 : 3;
    for (int i = 0; i < nl; i++) begin
      k = t - i;
      if (k >= 0 && k < nd) begin
        val = (which == 1) ? mdl[b][i][k] : mdl2[i][k];
        s[i*8 +: 8] = 8'(val);
      end
    end
    return s;
  endfunction

  task automatic push_tile(input int which, input int b, input int stall_t, input int stall_n);
    int nsl;
    nsl = (which == 1) ? 7 : 10;
    for (int t = 0; t < nsl; t++) begin
      for (int r = 0; r < ((t == stall_t) ? 1 + stall_n : 1); r++) begin
        exp_q.push_back(slice_of(which, b, t));
        exp_l_q.push_back(t == nsl - 1);
      end
    end
  endtask

  task automatic wr1(input bit tr, input int ix, input logic [63:0] v, input bit apply);
    en1 = 1'b1; wr_tr = tr; idx = 3'(ix); data = v;
    @(negedge clk);
    en1 = 1'b0;
    if (apply) begin
      for (int i = 0; i < 4; i++) begin
        for (int k = 0; k < 4; k++) begin
          if (!tr && i == ix) mdl[wb1][i][k] = int'($signed(v[k*8 +: 8]));
          if (tr && k == ix)  mdl[wb1][i][k] = int'($signed(v[i*8 +: 8]));
        end
      end
    end
  endtask

  task automatic wr2(input bit tr, input int ix, input logic [63:0] v, input bit apply);
    en2 = 1'b1; wr_tr = tr; idx = 3'(ix); data = v;
    @(negedge clk);
    en2 = 1'b0;
    if (apply) begin
      for (int i = 0; i < 8; i++) begin
        for (int k = 0; k < 3; k++) begin
          if (!tr && i == ix) mdl2[i][k] = int'($signed(v[k*8 +: 8]));
          if (tr && k == ix)  mdl2[i][k] = int'($signed(v[i*8 +: 8]));
        end
      end
    end
  endtask

  task automatic commit1();
    cm1 = 1'b1;
    @(negedge clk);
    cm1 = 1'b0;
    wb1 ^= 1;
  endtask

  task automatic fill_rand1();
    for (int r = 0; r < 4; r++) wr1(1'b0, r, {$urandom, $urandom}, 1'b1);
  endtask

  task automatic check_stream(input string tag, input int which);
    for (int n = 0; n < 200 && obs_q.size() < exp_q.size(); n++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk($sformatf("%s_slice%0d", tag, i), obs_q[i], exp_q[i]);
      chk($sformatf("%s_last%0d", tag, i), 64'(obs_l_q[i]), 64'(exp_l_q[i]));
      if (i > 0) chk($sformatf("%s_gap%0d", tag, i), 64'(obs_c_q[i] - obs_c_q[i-1]), 64'd1);
    end
    chk({tag, "_idle_valid"}, (which == 1) ? 64'(v1) : 64'(v2), 64'd0);
    chk({tag, "_idle_data"}, (which == 1) ? 64'(d1) : d2, 64'd0);
    exp_q.delete(); exp_l_q.delete();
    obs_q.delete(); obs_l_q.delete(); obs_c_q.delete();
  endtask

  initial begin
    logic [63:0] v;
    rst = 1'b1; en1 = 0; cm1 = 0; rs1 = 0; en2 = 0; cm2 = 0; rs2 = 0;
    wr_tr = 0; stall = 0; idx = '0; data = '0; wb1 = 0;
    mdl  = '{default: '{default: '{default: 0}}};
    mdl2 = '{default: '{default: 0}};
    repeat (2) @(negedge clk);
    chk("reset_valid", 64'(v1), 64'd0);
    chk("reset_data", 64'(d1), 64'd0);
    chk("reset_last", 64'(l1), 64'd0);
    chk("reset_wr_ready", 64'(wrdy1), 64'd1);
    chk("reset_rd_ready", 64'(rrdy1), 64'd0);
`ifdef SKEW_BUF_ERR_EN
    chk("reset_err", 64'(err1), 64'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Reset mid-operation discards a committed tile.
    fill_rand1();
    commit1();
    rst = 1'b1; rs1 = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("rst_hold_valid", 64'(v1), 64'd0);
      chk("rst_hold_data", 64'(d1), 64'd0);
    end
    rst = 1'b0; rs1 = 1'b0; wb1 = 0;
    mdl = '{default: '{default: '{default: 0}}};
    @(negedge clk);
    chk("post_rst_wr_ready", 64'(wrdy1), 64'd1);
    chk("post_rst_rd_ready", 64'(rrdy1), 64'd0);
    obs_q.delete(); obs_l_q.delete(); obs_c_q.delete();

    // Row fill M[i][k] = 4i+k+1.
    for (int r = 0; r < 4; r++) begin
      v = '0;
      for (int k = 0; k < 4; k++) v[k*8 +: 8] = 8'(4*r + k + 1);
      wr1(1'b0, r, v, 1'b1);
    end
    commit1();
    chk("row_rd_ready", 64'(rrdy1), 64'd1);
    push_tile(1, 0, -1, 0);
    rs1 = 1'b1;
    @(negedge clk);
    rs1 = 1'b0;
    chk("row_slice0_const", 64'(d1), 64'h0000_0001);
    repeat (3) @(negedge clk);
    chk("row_slice3_const", 64'(d1), 64'h0D0A_0704);
    check_stream("row", 1);

    // Same matrix via column writes, with junk in the unused upper data bits.
    for (int j = 0; j < 4; j++) begin
      v = {$urandom, 32'b0};
      for (int i = 0; i < 4; i++) v[i*8 +: 8] = 8'(4*i + j + 1);
      wr1(1'b1, j, v, 1'b1);
    end
    commit1();
    push_tile(1, 1, -1, 0);
    rs1 = 1'b1;
    @(negedge clk);
    rs1 = 1'b0;
    chk("col_slice0_const", 64'(d1), 64'h0000_0001);
    check_stream("col", 1);

    // Ping-pong: refill the other bank with negatives while the first drains.
    fill_rand1();
    commit1();
    push_tile(1, 0, -1, 0);
    rs1 = 1'b1;
    for (int r = 0; r < 4; r++) begin
      v = '0;
      for (int k = 0; k < 4; k++) v[k*8 +: 8] = 8'(-(4*r + k + 1));
      wr1(1'b0, r, v, 1'b1);
    end
    commit1();
    push_tile(1, 1, -1, 0);
    check_stream("pingpong", 1);
    rs1 = 1'b0;

    // Drain request in the commit cycle is not accepted; then stall at slice 2.
    fill_rand1();
    cm1 = 1'b1; rs1 = 1'b1;
    @(negedge clk);
    cm1 = 1'b0; wb1 ^= 1;
    chk("commit_cycle_no_accept", 64'(v1), 64'd0);
    chk("commit_cycle_rd_ready", 64'(rrdy1), 64'd1);
    push_tile(1, 0, 2, 3);
    @(negedge clk);
    rs1 = 1'b0;
    repeat (2) @(negedge clk);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    stall = 1'b0;
    check_stream("stall", 1);

    // Both banks full: writes and commits are refused.
    fill_rand1();
    commit1();
    fill_rand1();
    commit1();
    chk("full_wr_ready", 64'(wrdy1), 64'd0);
    chk("full_rd_ready", 64'(rrdy1), 64'd1);
    wr1(1'b0, 0, {$urandom, $urandom}, 1'b0);
    wr1(1'b1, 2, {$urandom, $urandom}, 1'b0);
    cm1 = 1'b1;
    @(negedge clk);
    cm1 = 1'b0;
`ifdef SKEW_BUF_ERR_EN
    chk("full_err_flag", 64'(err1), 64'd1);
`endif
    push_tile(1, 1, -1, 0);
    push_tile(1, 0, -1, 0);
    rs1 = 1'b1;
    check_stream("full", 1);
    rs1 = 1'b0;
    chk("drained_wr_ready", 64'(wrdy1), 64'd1);
    chk("drained_rd_ready", 64'(rrdy1), 64'd0);

    // 8 lanes x 3 deep: random rows, one column overwrite, out-of-range column ignored.
    for (int r = 0; r < 8; r++) wr2(1'b0, r, {$urandom, $urandom}, 1'b1);
    wr2(1'b1, 1, {$urandom, $urandom}, 1'b1);
    wr2(1'b1, 5, {$urandom, $urandom}, 1'b0);
`ifdef SKEW_BUF_ERR_EN
    chk("l8_err_flag", 64'(err2), 64'd1);
`endif
    cm2 = 1'b1;
    @(negedge clk);
    cm2 = 1'b0;
    chk("l8_rd_ready", 64'(rrdy2), 64'd1);
    push_tile(2, 0, -1, 0);
    rs2 = 1'b1;
    @(negedge clk);
    rs2 = 1'b0;
    check_stream("l8d3", 2);
    chk("l8_wr_ready", 64'(wrdy2), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
